rvfi_mem_wait_model: RTL and testbench

- Parametrised memory-side responder and protocol monitor for the picorv32 native memory interface in formal and sim testbenches.
- Replaces ad-hoc `mem_wait` shift-register restrictions with a bounded, configurable wait-state generator.
- Tracks the outstanding request and flags protocol violations by the core.
- Sits between the core's `mem_*` ports and free solver inputs (`ready_req`, `rdata_in`).

---
 rtl/rvfi_mem_wait_model.sv | 162 ++++++++++++++++
 tb/tb_rvfi_mem_wait_model.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_mem_wait_model.sv
// Memory-side responder and protocol monitor for the picorv32 native memory
// interface: bounded wait-state generation, request tracking, violation flag.
module rvfi_mem_wait_model #(
    parameter int XLEN     = 32,
    parameter int MIN_WAIT = 0,
    parameter int MAX_WAIT = 4,
    parameter int MODE     = 0,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN/8-1:0] mem_wstrb,
    input  logic              ready_req,
    input  logic [XLEN-1:0]   rdata_in,
    output logic              mem_ready,
    output logic [XLEN-1:0]   mem_rdata,
    output logic [CNT_W-1:0]  wait_count,
    output logic [CNT_W-1:0]  txn_count,
    output logic [CNT_W-1:0]  max_wait_seen,
    output logic              proto_error,
    output logic              pending
);
    localparam int SW = XLEN / 8;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] wait_count_r;
    logic [CNT_W-1:0] txn_count_r;
    logic [CNT_W-1:0] max_wait_r;
    logic             proto_error_r;
    logic             cap_instr_r;
    logic [XLEN-1:0]  cap_addr_r;
    logic [XLEN-1:0]  cap_wdata_r;
    logic [SW-1:0]    cap_wstrb_r;

    logic at_min_s;
    logic at_max_s;
    logic grant_s;
    logic ready_s;
    logic violation_s;

    // Write payload is only meaningful (and only compared) for captured writes.
    function automatic logic req_differs(
        input logic            instr_now,
        input logic            instr_cap,
        input logic [XLEN-1:0] addr_now,
        input logic [XLEN-1:0] addr_cap,
        input logic [XLEN-1:0] wdata_now,
        input logic [XLEN-1:0] wdata_cap,
        input logic [SW-1:0]   wstrb_now,
        input logic [SW-1:0]   wstrb_cap
    );
        return (instr_now != instr_cap) || (addr_now != addr_cap) ||
               ((wstrb_cap != {SW{1'b0}}) &&
                ((wdata_now != wdata_cap) || (wstrb_now != wstrb_cap)));
    endfunction

    if (MIN_WAIT == 0) begin : g_min_zero
        assign at_min_s = 1'b1;
    end else begin : g_min_cmp
        assign at_min_s = (wait_count_r >= MIN_CNT);
    end

    assign at_max_s = (wait_count_r == MAX_CNT);

    // Grant decision from registered state/count and ready_req only.
    always_comb begin
        grant_s = 1'b0;
        if (state_r == ST_WAIT) begin
            if (MODE == 1) begin
                grant_s = (wait_count_r == MIN_CNT);
            end else begin
                grant_s = at_min_s && (ready_req || at_max_s);
            end
        end else begin
            grant_s = 1'b0;
        end
    end

    // Protocol check against the captured request while it is pending.
    always_comb begin
        violation_s = 1'b0;
        if (state_r == ST_WAIT) begin
            violation_s = !mem_valid ||
                          req_differs(mem_instr, cap_instr_r, mem_addr, cap_addr_r,
                                      mem_wdata, cap_wdata_r, mem_wstrb, cap_wstrb_r);
        end else begin
            violation_s = 1'b0;
        end
    end

    assign ready_s       = enable && grant_s;
    assign mem_ready     = ready_s;
    assign mem_rdata     = ready_s ? rdata_in : {XLEN{1'b0}};
    assign wait_count    = wait_count_r;
    assign txn_count     = txn_count_r;
    assign max_wait_seen = max_wait_r;
    assign proto_error   = proto_error_r;
    assign pending       = (state_r == ST_WAIT);

    // Request FSM, wait/transaction counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            wait_count_r  <= {CNT_W{1'b0}};
            txn_count_r   <= {CNT_W{1'b0}};
            max_wait_r    <= {CNT_W{1'b0}};
            proto_error_r <= 1'b0;
            cap_instr_r   <= 1'b0;
            cap_addr_r    <= {XLEN{1'b0}};
            cap_wdata_r   <= {XLEN{1'b0}};
            cap_wstrb_r   <= {SW{1'b0}};
        end else begin
            if (violation_s) begin
                proto_error_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (enable && mem_valid) begin
                        state_r      <= ST_WAIT;
                        wait_count_r <= {CNT_W{1'b0}};
                        cap_instr_r  <= mem_instr;
                        cap_addr_r   <= mem_addr;
                        cap_wdata_r  <= mem_wdata;
                        cap_wstrb_r  <= mem_wstrb;
                    end
                end
                ST_WAIT: begin
                    if (ready_s) begin
                        state_r      <= ST_IDLE;
                        wait_count_r <= {CNT_W{1'b0}};
                        if (txn_count_r != CNT_SAT) begin
                            txn_count_r <= txn_count_r + CNT_ONE;
                        end
                        if (wait_count_r > max_wait_r) begin
                            max_wait_r <= wait_count_r;
                        end
                    end else if (enable && !at_max_s) begin
                        // The forced grant at MAX keeps this clamp unreachable in MODE 0.
                        wait_count_r <= wait_count_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rvfi_mem_wait_model.sv
// Scoreboard bench for rvfi_mem_wait_model: three instances cover MODE 0,
// fixed-latency MODE 1 and a narrow saturating counter.
module tb_rvfi_mem_wait_model;
    logic        clk = 1'b0;
    logic        reset, enable, mem_valid, mem_instr, ready_req;
    logic [31:0] mem_addr, mem_wdata, rdata_in;
    logic [3:0]  mem_wstrb;

    logic        mem_ready_a, proto_error_a, pending_a;
    logic [31:0] mem_rdata_a;
    logic [7:0]  wait_count_a, txn_count_a, max_wait_seen_a;
    logic        mem_ready_b, proto_error_b, pending_b;
    logic [31:0] mem_rdata_b;
    logic [7:0]  wait_count_b, txn_count_b, max_wait_seen_b;
    logic        mem_ready_c, proto_error_c, pending_c;
    logic [31:0] mem_rdata_c;
    logic [1:0]  wait_count_c, txn_count_c, max_wait_seen_c;

    typedef struct {
        logic [31:0] rdata;
        logic [7:0]  wc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rvfi_mem_wait_model #(.XLEN(32), .MIN_WAIT(0), .MAX_WAIT(4), .MODE(0), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .ready_req(ready_req), .rdata_in(rdata_in),
        .mem_ready(mem_ready_a), .mem_rdata(mem_rdata_a), .wait_count(wait_count_a),
        .txn_count(txn_count_a), .max_wait_seen(max_wait_seen_a),
        .proto_error(proto_error_a), .pending(pending_a));

    rvfi_mem_wait_model #(.XLEN(32), .MIN_WAIT(2), .MAX_WAIT(4), .MODE(1), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .ready_req(ready_req), .rdata_in(rdata_in),
        .mem_ready(mem_ready_b), .mem_rdata(mem_rdata_b), .wait_count(wait_count_b),
        .txn_count(txn_count_b), .max_wait_seen(max_wait_seen_b),
        .proto_error(proto_error_b), .pending(pending_b));

    rvfi_mem_wait_model #(.XLEN(32), .MIN_WAIT(0), .MAX_WAIT(3), .MODE(0), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .ready_req(ready_req), .rdata_in(rdata_in),
        .mem_ready(mem_ready_c), .mem_rdata(mem_rdata_c), .wait_count(wait_count_c),
        .txn_count(txn_count_c), .max_wait_seen(max_wait_seen_c),
        .proto_error(proto_error_c), .pending(pending_c));

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_valid = 1'b0;
        enable    = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Advances until the selected instance shows mem_ready, bounded by 'bound' cycles.
    task automatic wait_ready(input int sel, input int bound, output int lat,
                              output bit seen, output bit leak);
        logic        r;
        logic [31:0] d;
        lat = 0; seen = 1'b0; leak = 1'b0;
        while (!seen && lat <= bound) begin
            @(negedge clk);
            case (sel)
                0:       begin r = mem_ready_a; d = mem_rdata_a; end
                1:       begin r = mem_ready_b; d = mem_rdata_b; end
                default: begin r = mem_ready_c; d = mem_rdata_c; end
            endcase
            if (r === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (d !== 32'h0) leak = 1'b1;
                next_cycle();
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        rdata_in = 32'hFFFF_FFFF;
        do_reset();
        @(negedge clk);
        checks++; if (mem_ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", mem_ready_a); end
        checks++; if (mem_rdata_a !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata_a); end
        checks++; if ({wait_count_a, txn_count_a, max_wait_seen_a} !== 24'h0) begin failures++; $display("FAIL reset_counts got=%h exp=0", {wait_count_a, txn_count_a, max_wait_seen_a}); end
        checks++; if ({proto_error_a, pending_a, pending_b, pending_c} !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {proto_error_a, pending_a, pending_b, pending_c}); end
    endtask

    task automatic test_immediate_ready();
        int lat; bit seen, leak; exp_t e;
        do_reset();
        ready_req = 1'b1; rdata_in = 32'h1234_5678;
        mem_instr = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        exp_q.push_back('{rdata: 32'h1234_5678, wc: 8'd0, lat: 1});
        wait_ready(0, 10, lat, seen, leak);
        e = exp_q.pop_front();
        checks++; if (seen !== 1'b1 || lat !== e.lat) begin failures++; $display("FAIL imm_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (mem_rdata_a !== e.rdata) begin failures++; $display("FAIL imm_rdata got=%h exp=%h", mem_rdata_a, e.rdata); end
        checks++; if (wait_count_a !== e.wc || pending_a !== 1'b1) begin failures++; $display("FAIL imm_wait got=%0d/%b exp=%0d/1", wait_count_a, pending_a, e.wc); end
        next_cycle();
        mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (txn_count_a !== 8'd1) begin failures++; $display("FAIL imm_txn got=%0d exp=1", txn_count_a); end
        checks++; if (mem_ready_a !== 1'b0 || mem_rdata_a !== 32'h0 || pending_a !== 1'b0) begin failures++; $display("FAIL imm_idle got=%b/%h/%b exp=0/0/0", mem_ready_a, mem_rdata_a, pending_a); end
    endtask

    task automatic test_max_wait();
        int lat; bit seen, leak; exp_t e;
        do_reset();
        ready_req = 1'b0; rdata_in = 32'hDEAD_BEEF;
        mem_instr = 1'b0; mem_addr = 32'h200; mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        exp_q.push_back('{rdata: 32'hDEAD_BEEF, wc: 8'd4, lat: 5});
        wait_ready(0, 10, lat, seen, leak);
        e = exp_q.pop_front();
        checks++; if (seen !== 1'b1 || lat !== e.lat) begin failures++; $display("FAIL max_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (wait_count_a !== e.wc) begin failures++; $display("FAIL max_wc got=%0d exp=%0d", wait_count_a, e.wc); end
        checks++; if (mem_rdata_a !== e.rdata || leak !== 1'b0) begin failures++; $display("FAIL max_rdata got=%h leak=%b exp=%h leak=0", mem_rdata_a, leak, e.rdata); end
        next_cycle();
        mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (max_wait_seen_a !== 8'd4) begin failures++; $display("FAIL max_seen got=%0d exp=4", max_wait_seen_a); end
        checks++; if (mem_rdata_a !== 32'h0) begin failures++; $display("FAIL max_rdata_after got=%h exp=0", mem_rdata_a); end
    endtask

    task automatic test_back_to_back();
        int lat; bit seen, leak; exp_t e;
        do_reset();
        ready_req = 1'b1;
        mem_instr = 1'b1; mem_addr = 32'h300; mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rdata_in = 32'hA000_0000 + 32'(k);
            exp_q.push_back('{rdata: 32'hA000_0000 + 32'(k), wc: 8'd2, lat: 3});
            wait_ready(1, 10, lat, seen, leak);
            e = exp_q.pop_front();
            checks++; if (seen !== 1'b1 || lat !== e.lat) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", k, lat, e.lat); end
            checks++; if (mem_rdata_b !== e.rdata || wait_count_b !== e.wc || leak !== 1'b0) begin failures++; $display("FAIL b2b_data[%0d] got=%h/%0d exp=%h/%0d", k, mem_rdata_b, wait_count_b, e.rdata, e.wc); end
            next_cycle();
        end
        mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (txn_count_b !== 8'd3 || max_wait_seen_b !== 8'd2) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=3/2", txn_count_b, max_wait_seen_b); end
        checks++; if (proto_error_b !== 1'b0) begin failures++; $display("FAIL b2b_proto got=%b exp=0", proto_error_b); end
    endtask

    task automatic test_proto_addr();
        int lat; bit seen, leak; exp_t e;
        do_reset();
        ready_req = 1'b0; rdata_in = 32'h0BAD_F00D;
        mem_instr = 1'b0; mem_addr = 32'h100; mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        exp_q.push_back('{rdata: 32'h0BAD_F00D, wc: 8'd4, lat: 2});
        next_cycle();
        next_cycle();
        checks++; if (proto_error_a !== 1'b0) begin failures++; $display("FAIL proto_early got=%b exp=0", proto_error_a); end
        mem_addr = 32'h104;
        next_cycle();
        checks++; if (proto_error_a !== 1'b1) begin failures++; $display("FAIL proto_set got=%b exp=1", proto_error_a); end
        wait_ready(0, 10, lat, seen, leak);
        e = exp_q.pop_front();
        checks++; if (seen !== 1'b1 || lat !== e.lat || wait_count_a !== e.wc) begin failures++; $display("FAIL proto_handshake got=%0d/%0d exp=%0d/%0d", lat, wait_count_a, e.lat, e.wc); end
        next_cycle();
        mem_valid = 1'b0;
        repeat (3) next_cycle();
        checks++; if (proto_error_a !== 1'b1 || txn_count_a !== 8'd1) begin failures++; $display("FAIL proto_sticky got=%b/%0d exp=1/1", proto_error_a, txn_count_a); end
        do_reset();
        checks++; if (proto_error_a !== 1'b0) begin failures++; $display("FAIL proto_clear got=%b exp=0", proto_error_a); end
    endtask

    task automatic test_wdata_mask();
        int lat; bit seen, leak; exp_t e;
        do_reset();
        ready_req = 1'b0; rdata_in = 32'h5555_0001;
        mem_instr = 1'b0; mem_addr = 32'h200; mem_wdata = 32'h1111; mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        exp_q.push_back('{rdata: 32'h5555_0001, wc: 8'd4, lat: 4});
        next_cycle();
        mem_wdata = 32'h2222;
        wait_ready(0, 10, lat, seen, leak);
        e = exp_q.pop_front();
        checks++; if (seen !== 1'b1 || lat !== e.lat || mem_rdata_a !== e.rdata) begin failures++; $display("FAIL mask_read got=%0d/%h exp=%0d/%h", lat, mem_rdata_a, e.lat, e.rdata); end
        next_cycle();
        mem_valid = 1'b0;
        checks++; if (proto_error_a !== 1'b0) begin failures++; $display("FAIL mask_read_proto got=%b exp=0", proto_error_a); end
        next_cycle();
        rdata_in = 32'h5555_0002;
        mem_addr = 32'h300; mem_wdata = 32'h3333; mem_wstrb = 4'hF;
        mem_valid = 1'b1;
        exp_q.push_back('{rdata: 32'h5555_0002, wc: 8'd4, lat: 3});
        next_cycle();
        mem_wdata = 32'h4444;
        next_cycle();
        checks++; if (proto_error_a !== 1'b1) begin failures++; $display("FAIL mask_write_proto got=%b exp=1", proto_error_a); end
        wait_ready(0, 10, lat, seen, leak);
        e = exp_q.pop_front();
        checks++; if (seen !== 1'b1 || lat !== e.lat || wait_count_a !== e.wc) begin failures++; $display("FAIL mask_write got=%0d/%0d exp=%0d/%0d", lat, wait_count_a, e.lat, e.wc); end
        next_cycle();
        mem_valid = 1'b0;
    endtask

    task automatic test_enable();
        int lat; bit seen, leak; exp_t e;
        do_reset();
        ready_req = 1'b0; rdata_in = 32'hC0DE_0001;
        mem_instr = 1'b0; mem_addr = 32'h400; mem_wstrb = 4'h0;
        enable = 1'b0; mem_valid = 1'b1;
        next_cycle();
        checks++; if (pending_a !== 1'b0) begin failures++; $display("FAIL en_idle_capture got=%b exp=0", pending_a); end
        enable = 1'b1;
        next_cycle();
        next_cycle();
        checks++; if (wait_count_a !== 8'd1) begin failures++; $display("FAIL en_start got=%0d exp=1", wait_count_a); end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (wait_count_a !== 8'd1 || mem_ready_a !== 1'b0) begin failures++; $display("FAIL en_frozen[%0d] got=%0d/%b exp=1/0", i, wait_count_a, mem_ready_a); end
            next_cycle();
        end
        enable = 1'b1;
        exp_q.push_back('{rdata: 32'hC0DE_0001, wc: 8'd4, lat: 3});
        wait_ready(0, 10, lat, seen, leak);
        e = exp_q.pop_front();
        checks++; if (seen !== 1'b1 || lat !== e.lat || wait_count_a !== e.wc) begin failures++; $display("FAIL en_resume got=%0d/%0d exp=%0d/%0d", lat, wait_count_a, e.lat, e.wc); end
        next_cycle();
        mem_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ready_req = 1'b0; rdata_in = 32'h7777_7777;
        mem_addr = 32'h500; mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        checks++; if (wait_count_a !== 8'd2) begin failures++; $display("FAIL rmw_pre got=%0d exp=2", wait_count_a); end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; mem_valid = 1'b0;
        checks++; if (pending_a !== 1'b0 || mem_ready_a !== 1'b0 || mem_rdata_a !== 32'h0) begin failures++; $display("FAIL rmw_state got=%b/%b/%h exp=0/0/0", pending_a, mem_ready_a, mem_rdata_a); end
        checks++; if ({wait_count_a, txn_count_a, max_wait_seen_a} !== 24'h0 || proto_error_a !== 1'b0) begin failures++; $display("FAIL rmw_counts got=%h/%b exp=0/0", {wait_count_a, txn_count_a, max_wait_seen_a}, proto_error_a); end
    endtask

    task automatic test_saturation();
        int lat; bit seen, leak; exp_t e;
        logic [1:0] exp_txn;
        do_reset();
        ready_req = 1'b1;
        mem_addr = 32'h600; mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            rdata_in = 32'(k);
            exp_q.push_back('{rdata: 32'(k), wc: 8'd0, lat: 1});
            wait_ready(2, 10, lat, seen, leak);
            e = exp_q.pop_front();
            checks++; if (seen !== 1'b1 || lat !== e.lat || mem_rdata_c !== e.rdata || wait_count_c !== e.wc[1:0]) begin failures++; $display("FAIL sat_hs[%0d] got=%0d/%h exp=%0d/%h", k, lat, mem_rdata_c, e.lat, e.rdata); end
            next_cycle();
            exp_txn = (k > 3) ? 2'd3 : 2'(k);
            checks++; if (txn_count_c !== exp_txn) begin failures++; $display("FAIL sat_txn[%0d] got=%0d exp=%0d", k, txn_count_c, exp_txn); end
        end
        mem_valid = 1'b0;
        checks++; if (max_wait_seen_c !== 2'd0 || proto_error_c !== 1'b0) begin failures++; $display("FAIL sat_misc got=%0d/%b exp=0/0", max_wait_seen_c, proto_error_c); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; ready_req = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0; rdata_in = 32'h0;
        test_reset();
        test_immediate_ready();
        test_max_wait();
        test_back_to_back();
        test_proto_addr();
        test_wdata_mask();
        test_enable();
        test_reset_mid_wait();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end
endmodule
